serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder controller. Time-shares one full-adder cell (fa_bit) across
//  all WIDTH bit positions, one bit per clock, LSB first, with a registered carry.
//  It is the sequencer for the generate-built ripple adders where area matters
//  more than latency. It has a valid/ready operand input and a valid/ready result output.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range WIDTH >= 2
//  CNT_W   $clog2(WIDTH)  bit-counter width (localparam, derived, not overridable)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands a, b, cin are valid
//  in_ready   out  1      block can accept operands; = (state==IDLE)
//  a          in   WIDTH  addend A
//  b          in   WIDTH  addend B
//  cin        in   1      carry-in
//  out_valid  out  1      sum/cout hold a completed result; = (state==DONE)
//  out_ready  in   1      downstream accepts the result
//  sum        out  WIDTH  result, LSB-first shift register
//  cout       out  1      final carry-out
//  busy       out  1      = (state==RUN)
// BEHAVIOUR
//  Reset (async assert, sync-released by the system): state=IDLE, a_sr=b_sr=sum=0,
//   carry=0, cnt=0 -> in_ready=1, out_valid=0, busy=0, cout=0.
//  FSM: IDLE -> RUN -> DONE -> IDLE. Encoding is IDLE=2'b00, RUN=2'b01, DONE=2'b10;
//   2'b11 is illegal and returns to IDLE.
//  IDLE: on in_valid&&in_ready: a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, goto RUN.
//   Inputs a, b and cin are ignored on any cycle without the handshake.
//  RUN, every edge:
//   - fa_bit(a_sr[0], b_sr[0], carry) -> (s, c)
//   - sum <= {s, sum[WIDTH-1:1]}; a_sr and b_sr shift right (zero fill); carry <= c
//   - cnt <= cnt+1; at the edge where cnt==WIDTH-1: goto DONE
//  DONE: sum and cout (cout = carry) are stable while out_valid=1.
//   - out_valid&&out_ready: goto IDLE. sum/cout keep their value until the next accept.
//  Latency: out_valid rises WIDTH cycles after the accepting edge.
//   Throughput is 1 op per WIDTH+2 cycles: one IDLE bubble, because in_ready=0 in DONE.
//  Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); there is no overflow flag.
//  Back-pressure: out_ready may stay low indefinitely. The block holds DONE and
//   ignores in_valid meanwhile.
//  out_ready is ignored outside DONE.
//  in_valid may drop without being accepted; there is no stickiness.
//  Reset mid-RUN or mid-DONE aborts the operation immediately. No partial result is flagged.
//  cnt never exceeds WIDTH-1.
// STRUCTURE
//  Package serial_add_pkg: state localparams ST_IDLE/ST_RUN/ST_DONE, state width 2.
//  Sub-module fa_bit (combinational: s=a^b^c, co=ab|ac|bc). Exactly one instance.
//  Top level contains the FSM, the counter, the three shift registers and the carry flop.
//   There is no generate loop; the time-multiplexing replaces it.
// TESTING (WIDTH=8 unless stated)
//  1 a=8'h3C, b=8'h05, cin=0 -> out_valid 8 cycles after accept; sum=8'h41, cout=0.
//  2 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
//    a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//  3 out_ready low 5 cycles in DONE, with in_valid=1 pulsing -> out_valid, sum and cout
//    stay constant, in_ready=0, and no second operation starts.
//  4 in_valid and out_ready tied high, two ops -> accepts exactly 10 cycles apart;
//    both results correct.
//  5 rst_n low at cnt=3 in RUN -> out_valid=0, busy=0, in_ready=1, sum=0 at once;
//    the next op after release is correct.
//  6 WIDTH=2: a=2'b11, b=2'b11, cin=1 -> sum=2'b11, cout=1, after 2 cycles.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared state encoding for the bit-serial adder controller.
package serial_add_pkg;

    localparam int unsigned STATE_W = 2;

    // 2'b11 is unused; the FSM falls back to ST_IDLE if it is ever reached.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Single full-adder cell, time-shared across all bit positions by the controller.
module fa_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);

    // Sum and majority carry
    always_comb begin
        o_s  = i_a ^ i_b ^ i_c;
        o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one fa_bit cell, one bit per clock, LSB first, registered carry.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] w_a_sr_d;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] w_b_sr_d;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_sum_d;
    logic             r_carry;
    logic             w_carry_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_s;
    logic             w_co;

    fa_bit u_fa_bit (
        .i_a  (r_a_sr[0]),
        .i_b  (r_b_sr[0]),
        .i_c  (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    // State, datapath shift registers, carry and bit counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_a_sr  <= w_a_sr_d;
            r_b_sr  <= w_b_sr_d;
            r_sum   <= w_sum_d;
            r_carry <= w_carry_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Next-state and datapath update; everything holds unless a state acts on it
    always_comb begin
        w_state_d = r_state;
        w_a_sr_d  = r_a_sr;
        w_b_sr_d  = r_b_sr;
        w_sum_d   = r_sum;
        w_carry_d = r_carry;
        w_cnt_d   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_in_valid) begin
                    w_a_sr_d  = i_a;
                    w_b_sr_d  = i_b;
                    w_carry_d = i_cin;
                    w_cnt_d   = '0;
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                w_sum_d   = {w_s, r_sum[WIDTH-1:1]};
                w_a_sr_d  = {1'b0, r_a_sr[WIDTH-1:1]};
                w_b_sr_d  = {1'b0, r_b_sr[WIDTH-1:1]};
                w_carry_d = w_co;
                if (r_cnt == LAST_BIT) begin
                    // Park the counter at zero so it never passes WIDTH-1
                    w_cnt_d   = '0;
                    w_state_d = ST_DONE;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (i_out_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        o_in_ready  = (r_state == ST_IDLE);
        o_out_valid = (r_state == ST_DONE);
        o_busy      = (r_state == ST_RUN);
        o_sum       = r_sum;
        o_cout      = r_carry;
    end

endmodule
